// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: opcodes,
// control-vector width, hazard FSM states and scoreboard entry layout.
package mips_pkg;

    localparam int CTRL_W = 9;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL,
        ST_FLUSH
    } hz_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
    } sb_entry_t;

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// ID-stage hazard controller bus: pipeline-side inputs and the
// enables/flushes/control vector the controller drives back.
interface id_hazard_ctrl_if
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic              id_valid;
    logic [31:0]       id_instr;
    logic [CTRL_W-1:0] ctrl_in;
    logic              branch_taken;
    logic              stat_clr;
    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              exmem_flush;
    logic [CTRL_W-1:0] ctrl_out;
    logic              stalled;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_instr, ctrl_in, branch_taken, stat_clr,
        input  pc_write, ifid_write, ifid_flush, exmem_flush, ctrl_out,
               stalled, stall_count
    );

    modport slave (
        input  id_valid, id_instr, ctrl_in, branch_taken, stat_clr,
        output pc_write, ifid_write, ifid_flush, exmem_flush, ctrl_out,
               stalled, stall_count
    );

endinterface

// File: rtl/id_instr_decode.sv
// Register-usage decode of one MIPS instruction: which sources are read
// and which destination (if any) is written.
module id_instr_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output logic        uses_rs,
    output logic        uses_rt,
    output logic        dest_valid,
    output logic [4:0]  dest
);

    logic dv;

    // Classify by opcode; a $0 destination is never a real write.
    always_comb begin
        uses_rs = 1'b1;
        uses_rt = 1'b0;
        dest    = '0;
        dv      = 1'b0;
        case (instr[31:26])
            OP_RTYPE: begin
                uses_rt = 1'b1;
                dest    = instr[15:11];
                dv      = (instr != '0);
            end
            OP_LW: begin
                dest = instr[20:16];
                dv   = 1'b1;
            end
            OP_SW, OP_BEQ: begin
                uses_rt = 1'b1;
            end
            default: ;
        endcase
        dest_valid = dv & (dest != '0);
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Hazard and stall controller beside the ID stage of the 5-stage MIPS
// pipeline (no forwarding): RAW stalls from an EX/MEM/WB write
// scoreboard, branch flush sequencing and a saturating stall counter.
module id_hazard_ctrl
    import mips_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    id_hazard_ctrl_if.slave bus
);

    hz_state_e        state, state_nxt;
    sb_entry_t        sb_ex, sb_mem, sb_wb;
    logic             uses_rs, uses_rt, dest_valid;
    logic [4:0]       dest;
    logic             raw, issue, stall_now;
    logic [CNT_W-1:0] count;

    id_instr_decode u_decode (
        .instr      (bus.id_instr),
        .uses_rs    (uses_rs),
        .uses_rt    (uses_rt),
        .dest_valid (dest_valid),
        .dest       (dest)
    );

    function automatic logic src_hit(input logic used, input logic [4:0] r,
                                     input sb_entry_t ex, input sb_entry_t mem,
                                     input sb_entry_t wb);
        logic hit;
        hit = (ex.valid && ex.dest == r) || (mem.valid && mem.dest == r) ||
              (!WB_BYPASS && wb.valid && wb.dest == r);
        return used && (r != '0) && hit;
    endfunction

    // raw is the hazard without state gating; STALL re-evaluates it directly.
    assign raw = bus.id_valid &
                 (src_hit(uses_rs, bus.id_instr[25:21], sb_ex, sb_mem, sb_wb) |
                  src_hit(uses_rt, bus.id_instr[20:16], sb_ex, sb_mem, sb_wb));
    assign issue     = bus.id_valid & (state == ST_RUN) & ~raw & ~bus.branch_taken;
    assign stall_now = raw & (state != ST_FLUSH) & ~bus.branch_taken;

    // Advance the write scoreboard; a taken branch kills the instruction leaving EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_ex  <= '0;
            sb_mem <= '0;
            sb_wb  <= '0;
        end else begin
            sb_wb  <= sb_mem;
            sb_mem <= bus.branch_taken ? '0 : sb_ex;
            sb_ex  <= '{valid: issue & dest_valid, dest: dest};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    // Next state and pipeline control outputs; branch beats hazard everywhere.
    always_comb begin
        state_nxt       = state;
        bus.pc_write    = 1'b1;
        bus.ifid_write  = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.exmem_flush = 1'b0;
        bus.ctrl_out    = bus.id_valid ? bus.ctrl_in : '0;
        bus.stalled     = 1'b0;
        case (state)
            ST_RUN, ST_STALL: begin
                if (bus.branch_taken) state_nxt = ST_FLUSH;
                else if (raw)         state_nxt = ST_STALL;
                else                  state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
        if (!rst_n) begin
            bus.pc_write   = 1'b0;
            bus.ifid_write = 1'b0;
            bus.ctrl_out   = '0;
        end else if (bus.branch_taken) begin
            bus.ifid_flush  = 1'b1;
            bus.exmem_flush = 1'b1;
            bus.ctrl_out    = '0;
        end else if (state == ST_FLUSH) begin
            bus.ctrl_out = '0;
        end else if (stall_now) begin
            bus.pc_write   = 1'b0;
            bus.ifid_write = 1'b0;
            bus.ctrl_out   = '0;
            bus.stalled    = 1'b1;
        end
    end

    // Saturating stall-cycle counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          count <= '0;
        else if (bus.stat_clr)               count <= '0;
        else if (bus.stalled && count != '1) count <= count + 1'b1;
    end

    assign bus.stall_count = count;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: one instance with WB bypass and
// a 16-bit counter, one without bypass and a 4-bit counter.
module tb_id_hazard_ctrl;
    import mips_pkg::*;

    localparam logic [4:0] NRM = 5'b11000; // {pc_write, ifid_write, ifid_flush, exmem_flush, stalled}
    localparam logic [4:0] STL = 5'b00001;
    localparam logic [4:0] BRF = 5'b11110;
    localparam logic [4:0] FLS = 5'b11000;

    localparam logic [31:0] I_LW    = 32'h8C22_0000; // lw  $2, 0($1)
    localparam logic [31:0] I_ADD   = 32'h0044_1820; // add $3, $2, $4
    localparam logic [31:0] I_NOWR  = 32'h0023_00AA; // R-type, rd = $0
    localparam logic [31:0] I_BEQ   = 32'h1065_4321; // beq $3, $5
    localparam logic [31:0] I_ADD1  = 32'h0000_0820; // add $1, $0, $0
    localparam logic [31:0] I_ADD0  = 32'h0000_0020; // add $0, $0, $0
    localparam logic [31:0] I_RD0   = 32'h0000_1020; // add $2, $0, $0
    localparam logic [31:0] I_INDEP = 32'h00A6_3820; // add $7, $5, $6
    localparam logic [31:0] I_RD3   = 32'h0066_1020; // add $2, $3, $6

    typedef struct {
        bit          sel;
        string       tag;
        logic [4:0]  flags;
        logic [8:0]  ctrl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    id_hazard_ctrl_if #(.CNT_W(16)) bus_a ();
    id_hazard_ctrl_if #(.CNT_W(4))  bus_b ();

    id_hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(16)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    id_hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(4)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus_a.id_valid = 1'b0; bus_a.id_instr = '0; bus_a.ctrl_in = '0;
        bus_a.branch_taken = 1'b0; bus_a.stat_clr = 1'b0;
        bus_b.id_valid = 1'b0; bus_b.id_instr = '0; bus_b.ctrl_in = '0;
        bus_b.branch_taken = 1'b0; bus_b.stat_clr = 1'b0;
    endtask

    // One pipeline cycle on the selected instance (0 = A, 1 = B).
    task automatic step(input bit sel, input string tag, input logic v,
                        input logic [31:0] ins, input logic bt, input logic clr,
                        input logic [4:0] flags, input bit pass);
        exp_t       e;
        logic [8:0] c;
        logic [4:0] oflags;
        logic [8:0] octrl;
        @(posedge clk);
        #1;
        c = 9'($urandom_range(1, 511));
        drive_idle();
        if (!sel) begin
            bus_a.id_valid = v; bus_a.id_instr = ins; bus_a.ctrl_in = c;
            bus_a.branch_taken = bt; bus_a.stat_clr = clr;
        end else begin
            bus_b.id_valid = v; bus_b.id_instr = ins; bus_b.ctrl_in = c;
            bus_b.branch_taken = bt; bus_b.stat_clr = clr;
        end
        e.sel = sel; e.tag = tag; e.flags = flags; e.ctrl = pass ? c : 9'h000;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        if (!e.sel) begin
            oflags = {bus_a.pc_write, bus_a.ifid_write, bus_a.ifid_flush,
                      bus_a.exmem_flush, bus_a.stalled};
            octrl  = bus_a.ctrl_out;
        end else begin
            oflags = {bus_b.pc_write, bus_b.ifid_write, bus_b.ifid_flush,
                      bus_b.exmem_flush, bus_b.stalled};
            octrl  = bus_b.ctrl_out;
        end
        check_eq({e.tag, "/flags"}, 32'(oflags), 32'(e.flags));
        check_eq({e.tag, "/ctrl"},  32'(octrl),  32'(e.ctrl));
    endtask

    task automatic idle(input bit sel, input int n, input logic clr);
        for (int i = 0; i < n; i++) step(sel, "idle", 1'b0, '0, 1'b0, clr, NRM, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        bus_a.id_valid = 1'b1; bus_a.id_instr = I_ADD; bus_a.ctrl_in = 9'h1FF;
        bus_a.branch_taken = 1'b1;
        #12;
        check_eq("rst/flags", 32'({bus_a.pc_write, bus_a.ifid_write, bus_a.ifid_flush,
                                   bus_a.exmem_flush, bus_a.stalled}), 32'h0);
        check_eq("rst/ctrl",  32'(bus_a.ctrl_out), 32'h0);
        check_eq("rst/count", 32'(bus_a.stall_count), 32'h0);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use with WB bypass: two stall cycles.
        step(0, "lu_lw",   1'b1, I_LW,  1'b0, 1'b0, NRM, 1'b1);
        step(0, "lu_st1",  1'b1, I_ADD, 1'b0, 1'b0, STL, 1'b0);
        step(0, "lu_st2",  1'b1, I_ADD, 1'b0, 1'b0, STL, 1'b0);
        step(0, "lu_iss",  1'b1, I_ADD, 1'b0, 1'b0, NRM, 1'b1);
        check_eq("lu_count", 32'(bus_a.stall_count), 32'd2);
        idle(0, 3, 1'b0);

        // No-write producers: no stalls.
        step(0, "nowr",    1'b1, I_NOWR, 1'b0, 1'b0, NRM, 1'b1);
        step(0, "nowr_beq",1'b1, I_BEQ,  1'b0, 1'b0, NRM, 1'b1);
        idle(0, 3, 1'b0);

        // $0 destinations and $0 readers: no stalls.
        step(0, "z_add1",  1'b1, I_ADD1, 1'b0, 1'b0, NRM, 1'b1);
        step(0, "z_add0",  1'b1, I_ADD0, 1'b0, 1'b0, NRM, 1'b1);
        step(0, "z_rd0",   1'b1, I_RD0,  1'b0, 1'b0, NRM, 1'b1);
        check_eq("z_count", 32'(bus_a.stall_count), 32'd2);
        idle(0, 3, 1'b0);

        // Branch taken in the first STALL cycle.
        idle(0, 1, 1'b1);
        step(0, "br_lw",   1'b1, I_LW,   1'b0, 1'b0, STL & 5'b0 | NRM, 1'b1);
        step(0, "br_st",   1'b1, I_ADD,  1'b0, 1'b0, STL, 1'b0);
        step(0, "br_bt",   1'b1, I_ADD,  1'b1, 1'b0, BRF, 1'b0);
        step(0, "br_fl",   1'b1, I_ADD,  1'b0, 1'b0, FLS, 1'b0);
        check_eq("br_count", 32'(bus_a.stall_count), 32'd1);
        step(0, "br_run",  1'b1, I_RD3,  1'b0, 1'b0, NRM, 1'b1);
        idle(0, 3, 1'b0);

        // Reset asserted in the middle of a stall.
        step(0, "rm_lw",   1'b1, I_LW,   1'b0, 1'b0, NRM, 1'b1);
        step(0, "rm_st",   1'b1, I_ADD,  1'b0, 1'b0, STL, 1'b0);
        @(posedge clk);
        #1;
        bus_a.id_valid = 1'b1; bus_a.id_instr = I_ADD; bus_a.ctrl_in = 9'h155;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rm/flags", 32'({bus_a.pc_write, bus_a.ifid_write, bus_a.ifid_flush,
                                  bus_a.exmem_flush, bus_a.stalled}), 32'h0);
        check_eq("rm/ctrl",  32'(bus_a.ctrl_out), 32'h0);
        check_eq("rm/count", 32'(bus_a.stall_count), 32'h0);
        @(posedge clk);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, "rm_indep", 1'b1, I_INDEP, 1'b0, 1'b0, NRM, 1'b1);
        idle(0, 3, 1'b0);

        // No WB bypass: three stall cycles per load-use, 4-bit counter saturates.
        for (int k = 0; k < 7; k++) begin
            step(1, "b_lw",  1'b1, I_LW,  1'b0, 1'b0, NRM, 1'b1);
            step(1, "b_st1", 1'b1, I_ADD, 1'b0, 1'b0, STL, 1'b0);
            step(1, "b_st2", 1'b1, I_ADD, 1'b0, 1'b0, STL, 1'b0);
            step(1, "b_st3", 1'b1, I_ADD, 1'b0, 1'b0, STL, 1'b0);
            step(1, "b_iss", 1'b1, I_ADD, 1'b0, 1'b0, NRM, 1'b1);
            if (k == 0) check_eq("b_count3", 32'(bus_b.stall_count), 32'd3);
        end
        check_eq("b_sat", 32'(bus_b.stall_count), 32'd15);

        // Clear coinciding with a stall cycle wins.
        step(1, "c_lw",  1'b1, I_LW,  1'b0, 1'b0, NRM, 1'b1);
        step(1, "c_st1", 1'b1, I_ADD, 1'b0, 1'b1, STL, 1'b0);
        step(1, "c_st2", 1'b1, I_ADD, 1'b0, 1'b0, STL, 1'b0);
        check_eq("c_clr", 32'(bus_b.stall_count), 32'd0);
        step(1, "c_st3", 1'b1, I_ADD, 1'b0, 1'b0, STL, 1'b0);
        check_eq("c_inc", 32'(bus_b.stall_count), 32'd1);
        step(1, "c_iss", 1'b1, I_ADD, 1'b0, 1'b0, NRM, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
